// File: rtl/readout_arbiter_if.sv
// Signal bundle between the readout sequencers/host registers (master) and readout_arbiter (slave).
// CNT_W must match the arbiter's CNT_W.
interface readout_arbiter_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             enable;
    logic             req1;
    logic             req2;
    logic             clr_status;
    logic             adc1_busy;
    logic             adc2_busy;
    logic             adc1_start_trigger;
    logic             adc2_start_trigger;
    logic [1:0]       grant;
    logic             pend1;
    logic             pend2;
    logic             done1;
    logic             done2;
    logic             overrun1;
    logic             overrun2;
    logic             timeout_err;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;

    modport master (
        output enable, req1, req2, clr_status, adc1_busy, adc2_busy,
        input  adc1_start_trigger, adc2_start_trigger, grant, pend1, pend2,
               done1, done2, overrun1, overrun2, timeout_err, cnt1, cnt2
    );

    modport slave (
        input  enable, req1, req2, clr_status, adc1_busy, adc2_busy,
        output adc1_start_trigger, adc2_start_trigger, grant, pend1, pend2,
               done1, done2, overrun1, overrun2, timeout_err, cnt1, cnt2
    );
endinterface

// File: rtl/readout_arbiter.sv
// Two-channel arbiter for the shared row-readout engine: latches requests, issues start triggers,
// tracks busy to completion. Define READOUT_ARB_ROUND_ROBIN_EN for round-robin tie breaking.
module readout_arbiter #(
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input logic              TX_CLK,
    input logic              rst_n,
    readout_arbiter_if.slave bus
);
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StIssue, StWaitBusy, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last2_q, last2_d;  // 1 = ch2 was granted last
    logic [TW-1:0]    timer_q, timer_d;
    logic             trig1_q, trig1_d, trig2_q, trig2_d;
    logic             done1_q, done1_d, done2_q, done2_d;
    logic             pend1_q, pend1_d, pend2_q, pend2_d;
    logic             ovr1_q, ovr1_d, ovr2_q, ovr2_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic             leave1, leave2, pick2, gbusy;

    assign gbusy = (grant_q[0] & bus.adc1_busy) | (grant_q[1] & bus.adc2_busy);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last2_d = last2_q;
        timer_d = timer_q;
        trig1_d = 1'b0;
        trig2_d = 1'b0;
        done1_d = 1'b0;
        done2_d = 1'b0;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        tmo_d   = tmo_q & ~bus.clr_status;
        leave1  = 1'b0;
        leave2  = 1'b0;
        pick2   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.enable && (pend1_q || pend2_q) && !bus.adc1_busy && !bus.adc2_busy) begin
`ifdef READOUT_ARB_ROUND_ROBIN_EN
                    pick2 = pend2_q && (!pend1_q || !last2_q);
`else
                    pick2 = !pend1_q;
`endif
                    state_d = StIssue;
                    grant_d = pick2 ? 2'b10 : 2'b01;
                    trig1_d = !pick2;
                    trig2_d = pick2;
                end
            end
            StIssue: begin
                state_d = StWaitBusy;
                timer_d = TW'(1);
                leave1  = grant_q[0];
                leave2  = grant_q[1];
            end
            StWaitBusy: begin
                if (gbusy) begin
                    state_d = StRun;
                end else if (timer_q == TW'(ACK_TIMEOUT)) begin
                    state_d = StIdle;
                    grant_d = 2'b00;
                    tmo_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StRun: begin
                if (!gbusy) begin
                    state_d = StDone;
                    done1_d = grant_q[0];
                    done2_d = grant_q[1];
                    if (grant_q[0] && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
                    if (grant_q[1] && (cnt2_q != '1)) cnt2_d = cnt2_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                grant_d = 2'b00;
                last2_d = grant_q[1];
            end
            default: state_d = StIdle;
        endcase

        // A request landing on the edge that consumes the latch re-arms it without overrun.
        pend1_d = (pend1_q & ~leave1) | bus.req1;
        pend2_d = (pend2_q & ~leave2) | bus.req2;
        ovr1_d  = (ovr1_q & ~bus.clr_status) | (bus.req1 & pend1_q & ~leave1);
        ovr2_d  = (ovr2_q & ~bus.clr_status) | (bus.req2 & pend2_q & ~leave2);
    end

    always_ff @(posedge TX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            last2_q <= 1'b1;
            timer_q <= '0;
            trig1_q <= 1'b0;
            trig2_q <= 1'b0;
            done1_q <= 1'b0;
            done2_q <= 1'b0;
            pend1_q <= 1'b0;
            pend2_q <= 1'b0;
            ovr1_q  <= 1'b0;
            ovr2_q  <= 1'b0;
            tmo_q   <= 1'b0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last2_q <= last2_d;
            timer_q <= timer_d;
            trig1_q <= trig1_d;
            trig2_q <= trig2_d;
            done1_q <= done1_d;
            done2_q <= done2_d;
            pend1_q <= pend1_d;
            pend2_q <= pend2_d;
            ovr1_q  <= ovr1_d;
            ovr2_q  <= ovr2_d;
            tmo_q   <= tmo_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
        end
    end

    assign bus.adc1_start_trigger = trig1_q;
    assign bus.adc2_start_trigger = trig2_q;
    assign bus.grant              = grant_q;
    assign bus.pend1              = pend1_q;
    assign bus.pend2              = pend2_q;
    assign bus.done1              = done1_q;
    assign bus.done2              = done2_q;
    assign bus.overrun1           = ovr1_q;
    assign bus.overrun2           = ovr2_q;
    assign bus.timeout_err        = tmo_q;
    assign bus.cnt1               = cnt1_q;
    assign bus.cnt2               = cnt2_q;
endmodule

// File: tb/tb_readout_arbiter.sv
// Directed bench for readout_arbiter with a small engine model and a trigger-order scoreboard.
module tb_readout_arbiter;
    localparam int unsigned ACK_TO = 8;
    localparam int unsigned CNT_W  = 2;
    localparam int          MAXC   = (1 << CNT_W) - 1;

    logic TX_CLK = 1'b0;
    logic rst_n;
    always #5 TX_CLK = ~TX_CLK;

    readout_arbiter_if #(.CNT_W(CNT_W)) bus ();

    readout_arbiter #(.ACK_TIMEOUT(ACK_TO), .CNT_W(CNT_W)) dut (
        .TX_CLK (TX_CLK),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] exp_q[$];
    int         m_cnt1 = 0;
    int         m_cnt2 = 0;
    logic       eng_ack = 1'b1;
    int         busy_len = 100;
    int         eng_left = 0;
    logic       prev_trig = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic logic [31:0] outs();
        return 32'({bus.adc1_start_trigger, bus.adc2_start_trigger, bus.grant, bus.pend1,
                    bus.pend2, bus.done1, bus.done2, bus.overrun1, bus.overrun2,
                    bus.timeout_err, bus.cnt1, bus.cnt2});
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.adc1_busy;
            1:       return bus.adc1_start_trigger;
            2:       return (bus.grant == 2'b00) && !bus.pend1 && !bus.pend2 && !bus.adc1_busy
                            && !bus.adc2_busy && !bus.done1 && !bus.done2;
            default: return (bus.grant == 2'b01) && bus.adc1_busy;
        endcase
    endfunction

    // Waits on negedges for sig(sel) to reach lvl; an expired bound is a failed comparison.
    task automatic wait_sig(input string tag, input int sel, input logic lvl, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (sig(sel) === lvl) return;
            @(negedge TX_CLK);
        end
        check(tag, 32'(sig(sel)), 32'(lvl));
    endtask

    task automatic pulse_req(input logic r1, input logic r2);
        bus.req1 = r1;
        bus.req2 = r2;
        @(negedge TX_CLK);
        bus.req1 = 1'b0;
        bus.req2 = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr_status = 1'b1;
        @(negedge TX_CLK);
        bus.clr_status = 1'b0;
    endtask

    // Engine model: busy rises the cycle after a trigger and holds for busy_len cycles.
    always @(posedge TX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            eng_left      <= 0;
            bus.adc1_busy <= 1'b0;
            bus.adc2_busy <= 1'b0;
        end else if (eng_left > 1) begin
            eng_left <= eng_left - 1;
        end else if (eng_left == 1) begin
            eng_left      <= 0;
            bus.adc1_busy <= 1'b0;
            bus.adc2_busy <= 1'b0;
        end else if (eng_ack && (bus.adc1_start_trigger || bus.adc2_start_trigger)) begin
            eng_left      <= busy_len;
            bus.adc1_busy <= bus.adc1_start_trigger;
            bus.adc2_busy <= bus.adc2_start_trigger;
        end
    end

    always @(negedge TX_CLK) begin
        logic [1:0] tr;
        logic [1:0] e;
        tr = {bus.adc2_start_trigger, bus.adc1_start_trigger};
        if (rst_n && (tr != 2'b00)) begin
            check("trig_single_cycle", 32'(prev_trig), 0);
            if (exp_q.size() == 0) begin
                check("trig_unexpected", 32'(tr), 0);
            end else begin
                e = exp_q.pop_front();
                check("trig_order", 32'(tr), 32'(e));
                check("trig_grant", 32'(bus.grant), 32'(e));
            end
        end
        prev_trig = |tr;
    end

    initial begin
        logic seen;
        bus.enable     = 1'b0;
        bus.req1       = 1'b0;
        bus.req2       = 1'b0;
        bus.clr_status = 1'b0;
        rst_n          = 1'b0;
        repeat (2) @(negedge TX_CLK);
        check("reset_outs", outs(), 0);
        rst_n      = 1'b1;
        bus.enable = 1'b1;

        // Single request with a long busy window
        exp_q.push_back(2'b01);
        pulse_req(1'b1, 1'b0);
        check("t1_pend1", 32'(bus.pend1), 1);
        check("t1_no_early_trig", 32'(bus.adc1_start_trigger), 0);
        @(negedge TX_CLK);
        check("t1_trig1", 32'(bus.adc1_start_trigger), 1);
        check("t1_grant", 32'(bus.grant), 32'(2'b01));
        @(negedge TX_CLK);
        check("t1_trig_low", 32'(bus.adc1_start_trigger), 0);
        check("t1_pend1_clr", 32'(bus.pend1), 0);
        wait_sig("t1_busy_rise", 0, 1'b1, 10);
        wait_sig("t1_busy_fall", 0, 1'b0, busy_len + 10);
        check("t1_done_early", 32'(bus.done1), 0);
        @(negedge TX_CLK);
        check("t1_done1", 32'(bus.done1), 1);
        m_cnt1++;
        check("t1_cnt1", 32'(bus.cnt1), 32'(sat(m_cnt1)));
        @(negedge TX_CLK);
        check("t1_done1_low", 32'(bus.done1), 0);
        check("t1_grant_clr", 32'(bus.grant), 0);

        // Async reset in the middle of a readout
        busy_len = 30;
        exp_q.push_back(2'b01);
        pulse_req(1'b1, 1'b0);
        wait_sig("t6_run", 3, 1'b1, 20);
        rst_n = 1'b0;
        #1;
        check("t6_reset_outs", outs(), 0);
        @(negedge TX_CLK);
        @(negedge TX_CLK);
        rst_n  = 1'b1;
        m_cnt1 = 0;
        m_cnt2 = 0;
        seen   = 1'b0;
        repeat (40) begin
            @(negedge TX_CLK);
            seen = seen | bus.done1 | bus.done2;
        end
        check("t6_no_done", 32'(seen), 0);
        check("t6_cnt1", 32'(bus.cnt1), 0);

        // Simultaneous requests, then both again while ch1 is being issued
        busy_len = 5;
        exp_q.push_back(2'b01);
        pulse_req(1'b1, 1'b1);
        wait_sig("t2_first_issue", 1, 1'b1, 10);
`ifdef READOUT_ARB_ROUND_ROBIN_EN
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
`else
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
`endif
        pulse_req(1'b1, 1'b1);
        wait_sig("t2_idle", 2, 1'b1, 200);
        m_cnt1 += 2;
        m_cnt2 += 1;
        check("t2_overrun2", 32'(bus.overrun2), 1);
        check("t2_overrun1", 32'(bus.overrun1), 0);
        check("t2_cnt1", 32'(bus.cnt1), 32'(sat(m_cnt1)));
        check("t2_cnt2", 32'(bus.cnt2), 32'(sat(m_cnt2)));
        pulse_clr();
        check("t2_clr", 32'(bus.overrun2), 0);

        // Repeated ch2 requests during a ch1 readout queue only once
        busy_len = 10;
        exp_q.push_back(2'b01);
        pulse_req(1'b1, 1'b0);
        wait_sig("t3_run", 3, 1'b1, 20);
        exp_q.push_back(2'b10);
        repeat (3) begin
            pulse_req(1'b0, 1'b1);
            @(negedge TX_CLK);
        end
        check("t3_pend2", 32'(bus.pend2), 1);
        check("t3_overrun2", 32'(bus.overrun2), 1);
        check("t3_overrun1", 32'(bus.overrun1), 0);
        wait_sig("t3_idle", 2, 1'b1, 200);
        m_cnt1++;
        m_cnt2++;
        check("t3_cnt2", 32'(bus.cnt2), 32'(sat(m_cnt2)));
        pulse_clr();
        check("t3_clr", 32'(bus.overrun2), 0);

        // Engine never acknowledges: timeout, then the pending ch2 request is serviced
        eng_ack = 1'b0;
        exp_q.push_back(2'b01);
        pulse_req(1'b1, 1'b0);
        wait_sig("t4_issue", 1, 1'b1, 10);
        for (int j = 1; j <= int'(ACK_TO); j++) begin
            @(negedge TX_CLK);
            if (j == 1) begin
                bus.req2 = 1'b1;
                exp_q.push_back(2'b10);
            end
            if (j == 2) bus.req2 = 1'b0;
        end
        check("t4_not_early", 32'(bus.timeout_err), 0);
        @(negedge TX_CLK);
        check("t4_timeout", 32'(bus.timeout_err), 1);
        check("t4_grant_clr", 32'(bus.grant), 0);
        check("t4_pend2", 32'(bus.pend2), 1);
        eng_ack = 1'b1;
        wait_sig("t4_idle", 2, 1'b1, 200);
        m_cnt2++;
        check("t4_cnt1", 32'(bus.cnt1), 32'(sat(m_cnt1)));
        check("t4_cnt2", 32'(bus.cnt2), 32'(sat(m_cnt2)));
        pulse_clr();
        check("t4_clr", 32'(bus.timeout_err), 0);

        // Enable gating
        bus.enable = 1'b0;
        exp_q.push_back(2'b10);
        pulse_req(1'b0, 1'b1);
        seen = 1'b0;
        repeat (5) begin
            @(negedge TX_CLK);
            seen = seen | bus.adc1_start_trigger | bus.adc2_start_trigger;
        end
        check("t5_no_trig", 32'(seen), 0);
        check("t5_pend2", 32'(bus.pend2), 1);
        bus.enable = 1'b1;
        @(negedge TX_CLK);
        check("t5_trig2", 32'(bus.adc2_start_trigger), 1);
        wait_sig("t5_idle", 2, 1'b1, 200);
        m_cnt2++;
        check("t5_cnt2", 32'(bus.cnt2), 32'(sat(m_cnt2)));

        // Counter saturation from a fresh reset
        rst_n = 1'b0;
        @(negedge TX_CLK);
        @(negedge TX_CLK);
        rst_n  = 1'b1;
        m_cnt1 = 0;
        busy_len = 3;
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(2'b01);
            pulse_req(1'b1, 1'b0);
            wait_sig("t7_idle", 2, 1'b1, 100);
            m_cnt1++;
            check("t7_cnt1_sat", 32'(bus.cnt1), 32'(sat(m_cnt1)));
        end

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
